// File: rtl/freq_div_prog.sv
// Programmable clock divider with glitch-free divisor updates.
// oClk toggles every div_act iClk cycles; new divisors take effect only at half-period boundaries.
module freq_div_prog #(
  parameter int CNT_W     = 24,
  parameter int DIV_INIT  = 25,
  parameter bit RST_LEVEL = 1'b1
) (
  input  logic             iClk,
  input  logic             iReset_n,
  input  logic             iEn,
  input  logic [CNT_W-1:0] iDiv,
  input  logic             iLoad,
  output logic             oClk,
  output logic             oTick,
  output logic             oPending,
  output logic             oRun
);

  typedef enum logic {HOLD, RUN} mode_e;

  mode_e            mode;
  logic [CNT_W-1:0] count, count_nxt;
  logic [CNT_W-1:0] div_act, div_act_nxt;
  logic [CNT_W-1:0] div_pend, div_pend_nxt;
  logic             pending, pending_nxt;
  logic             clk_nxt, tick_nxt, run_nxt, boundary;

  always_comb begin
    mode         = (iEn && (div_act != '0)) ? RUN : HOLD;
    boundary     = (mode == RUN) && (count == div_act - CNT_W'(1));
    count_nxt    = count;
    div_act_nxt  = div_act;
    div_pend_nxt = div_pend;
    pending_nxt  = pending;
    clk_nxt      = oClk;
    tick_nxt     = 1'b0;
    case (mode)
      RUN: begin
        if (boundary) begin
          count_nxt = '0;
          clk_nxt   = ~oClk;
          tick_nxt  = ~oClk;
          // divisor swap rides on the toggle so no phase is ever truncated
          if (pending) begin
            div_act_nxt = div_pend;
            pending_nxt = 1'b0;
          end
        end else begin
          count_nxt = count + CNT_W'(1);
        end
      end
      HOLD: begin
        if (pending) begin
          div_act_nxt = div_pend;
          pending_nxt = 1'b0;
          count_nxt   = '0;
        end
      end
      default: ;
    endcase
    // a load on an applying edge queues the new value behind the one just applied
    if (iLoad) begin
      div_pend_nxt = iDiv;
      pending_nxt  = 1'b1;
    end
    run_nxt = iEn && (div_act_nxt != '0);
  end

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      count    <= '0;
      div_act  <= CNT_W'(DIV_INIT);
      div_pend <= '0;
      pending  <= 1'b0;
      oClk     <= RST_LEVEL;
      oTick    <= 1'b0;
      oRun     <= 1'b0;
    end else begin
      count    <= count_nxt;
      div_act  <= div_act_nxt;
      div_pend <= div_pend_nxt;
      pending  <= pending_nxt;
      oClk     <= clk_nxt;
      oTick    <= tick_nxt;
      oRun     <= run_nxt;
    end
  end

  assign oPending = pending;

endmodule
